// File: rtl/sysid_boot_checker.sv
// Boot-time sysid checker: reads the sysid ID and timestamp words over Avalon-MM
// and publishes registered pass/fail status for the CPU and the boot LED.
module sysid_boot_checker #(
  parameter logic [31:0] EXPECTED_ID    = 32'd0,
  parameter logic [31:0] EXPECTED_TS    = 32'd1643105791,
  parameter bit          AUTO_START     = 1'b1,
  parameter logic [15:0] TIMEOUT_CYCLES = 16'd255
) (
  input  logic        clock,
  input  logic        reset_n,
  output logic        m_address,
  output logic        m_read,
  input  logic        m_waitrequest,
  input  logic [31:0] m_readdata,
  input  logic        recheck,
  output logic        busy,
  output logic        done,
  output logic        id_ok,
  output logic        ts_ok,
  output logic        match,
  output logic        timeout,
  output logic [31:0] id_value,
  output logic [31:0] ts_value
);

  typedef enum logic [2:0] {IDLE, RD_ID, RD_TS, CHECK, DONE} state_t;

  state_t      state;
  logic [15:0] wait_cnt;
  logic        read_done;
  logic        read_stalled;
  logic        read_abort;

  assign read_done    = m_read && !m_waitrequest;
  assign read_stalled = m_read && m_waitrequest;
  // A zero TIMEOUT_CYCLES disables the abort entirely.
  assign read_abort   = read_stalled && (TIMEOUT_CYCLES != 16'd0) &&
                        (wait_cnt == TIMEOUT_CYCLES);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      wait_cnt  <= 16'd0;
      m_address <= 1'b0;
      m_read    <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      id_ok     <= 1'b0;
      ts_ok     <= 1'b0;
      match     <= 1'b0;
      timeout   <= 1'b0;
      id_value  <= 32'd0;
      ts_value  <= 32'd0;
    end else begin
      if (read_stalled) begin
        wait_cnt <= wait_cnt + 16'd1;
      end
      case (state)
        IDLE: begin
          if (AUTO_START || recheck) begin
            state     <= RD_ID;
            m_read    <= 1'b1;
            m_address <= 1'b0;
            wait_cnt  <= 16'd0;
            busy      <= 1'b1;
          end
        end
        RD_ID: begin
          if (read_done) begin
            id_value  <= m_readdata;
            m_address <= 1'b1;
            wait_cnt  <= 16'd0;
            state     <= RD_TS;
          end else if (read_abort) begin
            m_read  <= 1'b0;
            timeout <= 1'b1;
            id_ok   <= 1'b0;
            ts_ok   <= 1'b0;
            match   <= 1'b0;
            done    <= 1'b1;
            busy    <= 1'b0;
            state   <= DONE;
          end
        end
        RD_TS: begin
          if (read_done) begin
            ts_value <= m_readdata;
            m_read   <= 1'b0;
            state    <= CHECK;
          end else if (read_abort) begin
            m_read  <= 1'b0;
            timeout <= 1'b1;
            id_ok   <= 1'b0;
            ts_ok   <= 1'b0;
            match   <= 1'b0;
            done    <= 1'b1;
            busy    <= 1'b0;
            state   <= DONE;
          end
        end
        CHECK: begin
          id_ok   <= (id_value == EXPECTED_ID);
          ts_ok   <= (ts_value == EXPECTED_TS);
          match   <= (id_value == EXPECTED_ID) && (ts_value == EXPECTED_TS);
          timeout <= 1'b0;
          done    <= 1'b1;
          busy    <= 1'b0;
          state   <= DONE;
        end
        DONE: begin
          // Captured words are kept until the next run recaptures them.
          if (recheck) begin
            state     <= RD_ID;
            m_read    <= 1'b1;
            m_address <= 1'b0;
            wait_cnt  <= 16'd0;
            busy      <= 1'b1;
            done      <= 1'b0;
            id_ok     <= 1'b0;
            ts_ok     <= 1'b0;
            match     <= 1'b0;
            timeout   <= 1'b0;
          end
        end
        default: begin
          state  <= IDLE;
          m_read <= 1'b0;
          busy   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sysid_boot_checker.sv
// Scoreboard bench for sysid_boot_checker: one auto-start instance with a short
// timeout and stallable slave, one manual-start instance for the reset scenario.
module tb_sysid_boot_checker;

  localparam logic [31:0] EXP_TS = 32'd1643105791;
  localparam logic [31:0] ID_B   = 32'hCAFE0001;

  typedef struct {
    logic        id_ok;
    logic        ts_ok;
    logic        match;
    logic        timeout;
    logic [31:0] id_value;
    logic [31:0] ts_value;
    int          cyc;
  } exp_t;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  exp_t q_a[$];
  exp_t q_b[$];
  exp_t pop_a;
  exp_t pop_b;

  // Instance A: auto-start, 4-cycle timeout, stallable slave model
  logic        reset_a_n = 1'b0;
  logic        recheck_a = 1'b0;
  logic        m_address_a, m_read_a, wr_a;
  logic [31:0] rd_a;
  logic        busy_a, done_a, id_ok_a, ts_ok_a, match_a, timeout_a;
  logic [31:0] id_value_a, ts_value_a;
  logic [31:0] id_word_a = 32'd0;
  logic [31:0] ts_word_a = EXP_TS;
  int          wait_a = 0;
  logic        stuck_a = 1'b0;
  int          stall_a = 0;
  logic        prev_done_a = 1'b0;

  assign wr_a = m_read_a && ((m_address_a && stuck_a) || (stall_a < wait_a));
  assign rd_a = m_address_a ? ts_word_a : id_word_a;

  always @(posedge clock) begin
    if (m_read_a && wr_a) stall_a <= stall_a + 1;
    else                  stall_a <= 0;
  end

  sysid_boot_checker #(
    .EXPECTED_ID(32'd0), .EXPECTED_TS(EXP_TS), .AUTO_START(1'b1), .TIMEOUT_CYCLES(16'd4)
  ) dut_a (
    .clock(clock), .reset_n(reset_a_n),
    .m_address(m_address_a), .m_read(m_read_a), .m_waitrequest(wr_a), .m_readdata(rd_a),
    .recheck(recheck_a), .busy(busy_a), .done(done_a),
    .id_ok(id_ok_a), .ts_ok(ts_ok_a), .match(match_a), .timeout(timeout_a),
    .id_value(id_value_a), .ts_value(ts_value_a)
  );

  // Instance B: manual start, zero-wait slave
  logic        reset_b_n = 1'b0;
  logic        recheck_b = 1'b0;
  logic        m_address_b, m_read_b;
  logic [31:0] rd_b;
  logic        busy_b, done_b, id_ok_b, ts_ok_b, match_b, timeout_b;
  logic [31:0] id_value_b, ts_value_b;
  logic        prev_done_b = 1'b0;

  assign rd_b = m_address_b ? EXP_TS : ID_B;

  sysid_boot_checker #(
    .EXPECTED_ID(ID_B), .EXPECTED_TS(EXP_TS), .AUTO_START(1'b0), .TIMEOUT_CYCLES(16'd255)
  ) dut_b (
    .clock(clock), .reset_n(reset_b_n),
    .m_address(m_address_b), .m_read(m_read_b), .m_waitrequest(1'b0), .m_readdata(rd_b),
    .recheck(recheck_b), .busy(busy_b), .done(done_b),
    .id_ok(id_ok_b), .ts_ok(ts_ok_b), .match(match_b), .timeout(timeout_b),
    .id_value(id_value_b), .ts_value(ts_value_b)
  );

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  function automatic exp_t mk(input logic i, input logic t, input logic m, input logic to,
                              input logic [31:0] idv, input logic [31:0] tsv, input int lat);
    exp_t e;
    e.id_ok = i; e.ts_ok = t; e.match = m; e.timeout = to;
    e.id_value = idv; e.ts_value = tsv; e.cyc = lat;
    return e;
  endfunction

  // Must be called at a negedge; pushes the expected result, pulses recheck for one edge.
  task automatic applyStimulus(input bit sel, input exp_t e);
    e.cyc = cyc + e.cyc;
    if (sel) begin q_b.push_back(e); recheck_b = 1'b1; end
    else     begin q_a.push_back(e); recheck_a = 1'b1; end
    @(negedge clock);
    recheck_a = 1'b0;
    recheck_b = 1'b0;
  endtask

  task automatic waitDone(input bit sel, input int budget);
    int n = 0;
    while (((sel ? q_b.size() : q_a.size()) != 0) && n < budget) begin
      @(negedge clock);
      n++;
    end
    if ((sel ? q_b.size() : q_a.size()) != 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL done_wait_%s: got no done after %0d cycles, expected done", sel ? "b" : "a", budget);
      if (sel) q_b.delete(); else q_a.delete();
    end
  endtask

  // Monitors: every rising edge of done is matched against the oldest expectation.
  always @(negedge clock) begin
    if (done_a && !prev_done_a) begin
      if (q_a.size() == 0) begin
        checks++; errors++;
        $display("[TB] FAIL unexpected_done_a: got done at cycle %0d, expected none", cyc);
      end else begin
        pop_a = q_a.pop_front();
        checkOutput("a_done_cycle", cyc, pop_a.cyc);
        checkOutput("a_id_ok", id_ok_a, pop_a.id_ok);
        checkOutput("a_ts_ok", ts_ok_a, pop_a.ts_ok);
        checkOutput("a_match", match_a, pop_a.match);
        checkOutput("a_timeout", timeout_a, pop_a.timeout);
        checkOutput("a_id_value", id_value_a, pop_a.id_value);
        checkOutput("a_ts_value", ts_value_a, pop_a.ts_value);
        checkOutput("a_busy_at_done", busy_a, 1'b0);
      end
    end
    prev_done_a <= done_a;
  end

  always @(negedge clock) begin
    if (done_b && !prev_done_b) begin
      if (q_b.size() == 0) begin
        checks++; errors++;
        $display("[TB] FAIL unexpected_done_b: got done at cycle %0d, expected none", cyc);
      end else begin
        pop_b = q_b.pop_front();
        checkOutput("b_done_cycle", cyc, pop_b.cyc);
        checkOutput("b_id_ok", id_ok_b, pop_b.id_ok);
        checkOutput("b_ts_ok", ts_ok_b, pop_b.ts_ok);
        checkOutput("b_match", match_b, pop_b.match);
        checkOutput("b_timeout", timeout_b, pop_b.timeout);
        checkOutput("b_id_value", id_value_b, pop_b.id_value);
        checkOutput("b_ts_value", ts_value_b, pop_b.ts_value);
      end
    end
    prev_done_b <= done_b;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got no completion, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    @(negedge clock);
    @(negedge clock);
    checkOutput("rst_m_read", m_read_a, 1'b0);
    checkOutput("rst_m_address", m_address_a, 1'b0);
    checkOutput("rst_busy", busy_a, 1'b0);
    checkOutput("rst_done", done_a, 1'b0);
    checkOutput("rst_status", {id_ok_a, ts_ok_a, match_a, timeout_a}, 4'b0000);
    checkOutput("rst_id_value", id_value_a, 32'd0);
    checkOutput("rst_ts_value", ts_value_a, 32'd0);

    // Auto-start, zero wait: m_read high for exactly edges 1..2, done after edge 4
    q_a.push_back(mk(1'b1, 1'b1, 1'b1, 1'b0, 32'd0, EXP_TS, cyc + 4));
    reset_a_n = 1'b1;
    @(negedge clock);
    checkOutput("e1_read", {m_read_a, m_address_a, busy_a, done_a}, 4'b1010);
    @(negedge clock);
    checkOutput("e2_read", {m_read_a, m_address_a, busy_a}, 3'b111);
    @(negedge clock);
    checkOutput("e3_read", {m_read_a, busy_a, done_a}, 3'b010);
    waitDone(1'b0, 20);

    // Timestamp off by one
    ts_word_a = EXP_TS - 32'd1;
    applyStimulus(1'b0, mk(1'b1, 1'b0, 1'b0, 1'b0, 32'd0, EXP_TS - 32'd1, 4));
    checkOutput("recheck_clears_done", done_a, 1'b0);
    waitDone(1'b0, 20);

    // Three wait states on each read: bus held stable, done after edge 10
    ts_word_a = EXP_TS;
    wait_a = 3;
    applyStimulus(1'b0, mk(1'b1, 1'b1, 1'b1, 1'b0, 32'd0, EXP_TS, 10));
    for (int k = 1; k <= 9; k++) begin
      checkOutput($sformatf("ws_read_e%0d", k), m_read_a, (k <= 8) ? 1'b1 : 1'b0);
      if (k <= 8) checkOutput($sformatf("ws_addr_e%0d", k), m_address_a, (k >= 5) ? 1'b1 : 1'b0);
      @(negedge clock);
    end
    waitDone(1'b0, 20);

    // Timestamp read stuck: abort on the 5th stalled edge of RD_TS (edge 7)
    wait_a = 0;
    stuck_a = 1'b1;
    id_word_a = 32'h12345678;
    applyStimulus(1'b0, mk(1'b0, 1'b0, 1'b0, 1'b1, 32'h12345678, EXP_TS, 7));
    waitDone(1'b0, 20);
    checkOutput("abort_m_read", m_read_a, 1'b0);

    // New ID; recheck held through the busy period and the CHECK->DONE edge is ignored
    stuck_a = 1'b0;
    id_word_a = 32'hDEADBEEF;
    applyStimulus(1'b0, mk(1'b0, 1'b1, 1'b0, 1'b0, 32'hDEADBEEF, EXP_TS, 4));
    checkOutput("recheck_clears_timeout", {done_a, timeout_a}, 2'b00);
    recheck_a = 1'b1;
    repeat (3) @(negedge clock);
    recheck_a = 1'b0;
    repeat (4) @(negedge clock);
    checkOutput("single_check", {done_a, busy_a, m_read_a}, 3'b100);
    waitDone(1'b0, 20);

    // Instance B: stays idle without recheck
    reset_b_n = 1'b1;
    repeat (5) @(negedge clock);
    checkOutput("b_idle", {m_read_b, busy_b, done_b}, 3'b000);
    applyStimulus(1'b1, mk(1'b1, 1'b1, 1'b1, 1'b0, ID_B, EXP_TS, 4));
    @(negedge clock);
    checkOutput("b_in_rd_ts", {m_read_b, m_address_b, id_value_b == ID_B}, 3'b111);
    #1 reset_b_n = 1'b0;
    #1;
    checkOutput("b_rst_bus", {m_read_b, m_address_b, busy_b, done_b}, 4'b0000);
    checkOutput("b_rst_status", {id_ok_b, ts_ok_b, match_b, timeout_b}, 4'b0000);
    checkOutput("b_rst_id_value", id_value_b, 32'd0);
    checkOutput("b_rst_ts_value", ts_value_b, 32'd0);
    q_b.delete();
    @(negedge clock);
    reset_b_n = 1'b1;
    repeat (4) @(negedge clock);
    checkOutput("b_idle_after_reset", {m_read_b, busy_b, done_b}, 3'b000);
    applyStimulus(1'b1, mk(1'b1, 1'b1, 1'b1, 1'b0, ID_B, EXP_TS, 4));
    waitDone(1'b1, 20);

    repeat (2) @(negedge clock);
    checkOutput("queues_empty", q_a.size() + q_b.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
